ps2_keys_lr: RTL and testbench

- PS/2 keyboard front end that drives the `left`/`right` level inputs of the ball position updater.
- Samples raw `ps2_clk`/`ps2_data`, deframes 11-bit scan-code frames and tracks make/break state of Left/Right arrows and A/D keys.
- Outputs held-key levels on the system clock, with a received-byte strobe and error flags for debug LEDs.

---
 rtl/ps2_keys_lr.sv | 168 ++++++++++++++++
 tb/tb_ps2_keys_lr.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keys_lr.sv
// PS/2 keyboard front end: deframes scan codes and tracks held
// Left/Right arrow and A/D keys as left/right level outputs.
module ps2_keys_lr #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int TO_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       left,
   output logic       right,
   output logic [7:0] scan_code,
   output logic       byte_valid,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]      clk_sync;
   logic [1:0]      dat_sync;
   logic            clk_prev;
   logic            fe;
   logic            din;

   state_t          state;
   logic [3:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par;
   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   logic ext, brk;
   logic k_la, k_ra, k_a, k_d;
   logic nx_ext, nx_brk;
   logic nx_la, nx_ra, nx_a, nx_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         clk_prev <= clk_sync[1];
      end
   end

   assign fe     = clk_prev & ~clk_sync[1];
   assign din    = dat_sync[1];
   assign to_hit = (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         to_cnt     <= '0;
         scan_code  <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         // Idle or just-seen edge keeps the watchdog at zero
         if (state == IDLE || fe || to_hit)
            to_cnt <= '0;
         else
            to_cnt <= to_cnt + 1'b1;

         if (state != IDLE && !fe && to_hit) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end else if (fe) begin
            unique case (state)
               IDLE: begin
                  if (!din) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {din, shreg[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  par   <= din;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (din && (^{shreg, par})) begin
                     scan_code  <= shreg;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      nx_ext = ext;
      nx_brk = brk;
      nx_la  = k_la;
      nx_ra  = k_ra;
      nx_a   = k_a;
      nx_d   = k_d;
      if (byte_valid) begin
         unique case (scan_code)
            8'hE0: nx_ext = 1'b1;
            8'hF0: nx_brk = 1'b1;
            default: begin
               if (ext && scan_code == 8'h6B)
                  nx_la = !brk;
               if (ext && scan_code == 8'h74)
                  nx_ra = !brk;
               if (!ext && scan_code == 8'h1C)
                  nx_a = !brk;
               if (!ext && scan_code == 8'h23)
                  nx_d = !brk;
               nx_ext = 1'b0;
               nx_brk = 1'b0;
            end
         endcase
      end else if (frame_err) begin
         nx_ext = 1'b0;
         nx_brk = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext   <= 1'b0;
         brk   <= 1'b0;
         k_la  <= 1'b0;
         k_ra  <= 1'b0;
         k_a   <= 1'b0;
         k_d   <= 1'b0;
         left  <= 1'b0;
         right <= 1'b0;
      end else begin
         ext   <= nx_ext;
         brk   <= nx_brk;
         k_la  <= nx_la;
         k_ra  <= nx_ra;
         k_a   <= nx_a;
         k_d   <= nx_d;
         left  <= nx_la | nx_a;
         right <= nx_ra | nx_d;
      end
   end

endmodule

// File: tb/tb_ps2_keys_lr.sv
// Bench for ps2_keys_lr: directed key sequences plus random frames
// checked against a byte-level keyboard model.
module tb_ps2_keys_lr;

   localparam int TO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       left, right;
   logic [7:0] scan_code;
   logic       byte_valid, frame_err;

   int errors = 0;
   int checks = 0;
   int bv_cnt = 0;
   int fe_cnt = 0;
   time last_edge = 0;

   // model state
   bit m_ext, m_brk, m_la, m_ra, m_a, m_d;
   int evq[$];

   always #5 clk = ~clk;

   ps2_keys_lr #(
      .TIMEOUT_CYCLES(TO),
      .TO_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .left(left),
      .right(right),
      .scan_code(scan_code),
      .byte_valid(byte_valid),
      .frame_err(frame_err)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic void model_clear();
      m_ext = 0; m_brk = 0;
      m_la = 0; m_ra = 0; m_a = 0; m_d = 0;
   endfunction

   function automatic void model_err();
      m_ext = 0;
      m_brk = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
         if (m_ext && b == 8'h6B) m_la = !m_brk;
         if (m_ext && b == 8'h74) m_ra = !m_brk;
         if (!m_ext && b == 8'h1C) m_a = !m_brk;
         if (!m_ext && b == 8'h23) m_d = !m_brk;
         m_ext = 0;
         m_brk = 0;
      end
   endfunction

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (reset) begin
         if (byte_valid) begin
            bv_cnt++;
            if (evq.size() == 0 || evq[0] < 0) begin
               checks++;
               errors++;
               $display("FAIL byte_valid: got pulse required none at %0t",
                        $time);
            end else begin
               chk("scan_code", scan_code, evq[0]);
               void'(evq.pop_front());
            end
         end
         if (frame_err) begin
            fe_cnt++;
            checks++;
            if (evq.size() == 0 || evq[0] >= 0) begin
               errors++;
               $display("FAIL frame_err: got pulse required none at %0t",
                        $time);
            end else begin
               void'(evq.pop_front());
            end
         end
         if ($time - last_edge >= 50) begin
            chk("left", left, m_la | m_a);
            chk("right", right, m_ra | m_d);
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                             input bit bad_stop = 0);
      logic [10:0] f;
      int h;
      f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         h = $urandom_range(30, 60);
         ps2_data = f[i];
         #(h);
         ps2_clk = 1'b0;
         last_edge = $time;
         if (i == 10) begin
            if (bad_par || bad_stop) begin
               evq.push_back(-1);
               model_err();
            end else begin
               evq.push_back(int'(b));
               model_byte(b);
            end
         end
         #(h);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      #($urandom_range(20, 150));
   endtask

   task automatic send_bits(input int n);
      int h;
      for (int i = 0; i < n; i++) begin
         h = $urandom_range(30, 60);
         ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         #(h);
         ps2_clk = 1'b0;
         last_edge = $time;
         #(h);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   task automatic send_partial(input int ndata);
      send_bits(ndata + 1);
      evq.push_back(-1);
      model_err();
      repeat (TO + 30) @(posedge clk);
   endtask

   task automatic reset_mid_frame();
      send_bits(4);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_left", left, 0);
      chk("rst_right", right, 0);
      chk("rst_scan", scan_code, 0);
      chk("rst_bv", byte_valid, 0);
      chk("rst_fe", frame_err, 0);
      evq.delete();
      model_clear();
      last_edge = $time;
      reset = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   int bv0, fe0;
   logic [7:0] tbl[9] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h1C,
                          8'h23, 8'hE0, 8'hF0, 8'h00};

   initial begin
      model_clear();
      #22;
      chk("init_left", left, 0);
      chk("init_right", right, 0);
      chk("init_scan", scan_code, 0);
      chk("init_bv", byte_valid, 0);
      chk("init_fe", frame_err, 0);
      reset = 1'b1;
      last_edge = $time;
      repeat (5) @(posedge clk);

      bv0 = bv_cnt;
      send_frame(8'hE0);
      send_frame(8'h6B);
      #100;
      chk("E06B_bv", bv_cnt - bv0, 2);
      chk("E06B_scan", scan_code, 8'h6B);
      chk("E06B_left", left, 1);
      chk("E06B_right", right, 0);

      fe0 = fe_cnt;
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h6B);
      #100;
      chk("brk_left", left, 0);
      chk("brk_scan", scan_code, 8'h6B);
      chk("brk_fe", fe_cnt - fe0, 0);

      bv0 = bv_cnt;
      fe0 = fe_cnt;
      send_frame(8'h1C, 1);
      #100;
      chk("par_fe", fe_cnt - fe0, 1);
      chk("par_bv", bv_cnt - bv0, 0);
      chk("par_left", left, 0);
      send_frame(8'h1C);
      #100;
      chk("A_left", left, 1);

      send_frame(8'h1C);
      send_frame(8'hE0);
      send_frame(8'h6B);
      send_frame(8'hF0);
      send_frame(8'h1C);
      #100;
      chk("overlap_left", left, 1);
      send_frame(8'hE0);
      send_frame(8'hF0);
      send_frame(8'h6B);
      #100;
      chk("rel_left", left, 0);

      fe0 = fe_cnt;
      send_partial(4);
      chk("to_fe", fe_cnt - fe0, 1);
      send_frame(8'h23);
      #100;
      chk("D_right", right, 1);

      send_frame(8'h23);
      send_frame(8'hE0);
      send_partial(2);
      send_frame(8'h74);
      #100;
      chk("noext_right", right, 1);
      chk("noext_scan", scan_code, 8'h74);
      reset_mid_frame();
      chk("post_rst_right", right, 0);
      send_frame(8'hE0);
      send_frame(8'h74);
      #100;
      chk("E074_right", right, 1);
      chk("E074_left", left, 0);

      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 39);
         if (r == 0)
            send_partial($urandom_range(0, 9));
         else if (r == 1)
            reset_mid_frame();
         else if (r < 5)
            send_frame(8'($urandom), 1, 0);
         else if (r < 7)
            send_frame(8'($urandom), 0, 1);
         else if (r < 10)
            send_frame(8'($urandom));
         else
            send_frame(tbl[$urandom_range(0, 7)]);
      end

      repeat (100) @(posedge clk);
      chk("evq_empty", evq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
